// File: rtl/ddr3_req_bridge32.sv
// ddr3_req_bridge32: bridges a 32-bit valid/ready request port onto the 128-bit ddr3_core inport.
// Optional feature macro: DDR3_BRIDGE_ID_CHECK_EN (compare response IDs with the tracking FIFO head).
module ddr3_req_bridge32 #(
  parameter int OUTSTANDING = 4
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic           req_we_i,
  input  logic [31:0]    req_addr_i,
  input  logic [31:0]    req_wdata_i,
  input  logic [3:0]     req_be_i,
  output logic           resp_valid_o,
  output logic [31:0]    resp_rdata_o,
  output logic           resp_err_o,
  output logic           busy_o,
  output logic           id_err_o,
  output logic [15:0]    inport_wr_o,
  output logic           inport_rd_o,
  output logic [31:0]    inport_addr_o,
  output logic [127:0]   inport_write_data_o,
  output logic [15:0]    inport_req_id_o,
  input  logic           inport_accept_i,
  input  logic           inport_ack_i,
  input  logic           inport_error_i,
  input  logic [15:0]    inport_resp_id_i,
  input  logic [127:0]   inport_read_data_i
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(OUTSTANDING);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic [15:0] id;
    logic [1:0]  lane;
    logic        we;
    logic        err;
  } entry_t;

  state_t         state_q, state_d;
  logic [15:0]    wr_q, wr_d;
  logic           rd_q, rd_d;
  logic [31:0]    addr_q, addr_d;
  logic [127:0]   wdata_q, wdata_d;
  logic [15:0]    req_id_q, req_id_d;
  logic [15:0]    id_cnt_q, id_cnt_d;

  entry_t         fifo_q [OUTSTANDING];
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  cnt_q;

  logic           resp_valid_q, resp_valid_d;
  logic [31:0]    resp_rdata_q, resp_rdata_d;
  logic           resp_err_q, resp_err_d;
  logic           id_err_q, id_err_d;

  logic           capture;
  logic           pop;
  logic           fifo_empty;
  logic           illegal_wr;
  logic [1:0]     req_lane;
  logic           id_mismatch;
  entry_t         head;
  entry_t         new_entry;
  logic           unused_addr_lsb;

  assign req_lane        = req_addr_i[3:2];
  assign illegal_wr      = req_we_i && (req_be_i == 4'h0);
  assign fifo_empty      = (cnt_q == '0);
  assign req_ready_o     = ((state_q == S_IDLE) || inport_accept_i) && (cnt_q < DEPTH);
  assign capture         = req_valid_i && req_ready_o;
  // Acks against an empty FIFO have nothing to pop and produce no response.
  assign pop             = inport_ack_i && !fifo_empty;
  assign head            = fifo_q[rptr_q];
  assign unused_addr_lsb = ^req_addr_i[1:0];

  always_comb begin
    new_entry      = '0;
    new_entry.id   = id_cnt_q;
    new_entry.lane = req_lane;
    new_entry.we   = req_we_i;
    new_entry.err  = illegal_wr;
  end

`ifdef DDR3_BRIDGE_ID_CHECK_EN
  assign id_mismatch = pop && (inport_resp_id_i != head.id);
`else
  logic unused_resp_id;
  assign id_mismatch    = 1'b0;
  assign unused_resp_id = ^inport_resp_id_i;
`endif

  // Hold-register FSM
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    req_id_d = req_id_q;
    id_cnt_d = id_cnt_q;
    if (capture) begin
      state_d  = S_ISSUE;
      addr_d   = {req_addr_i[31:4], 4'h0};
      req_id_d = id_cnt_q;
      id_cnt_d = (id_cnt_q == 16'hFFFF) ? 16'h0001 : id_cnt_q + 16'h0001;
      if (req_we_i && !illegal_wr) begin
        wr_d    = {12'h000, req_be_i} << {req_lane, 2'b00};
        rd_d    = 1'b0;
        wdata_d = {4{req_wdata_i}};
      end else begin
        // Reads, and writes with no byte enables, go out as a read of the line.
        wr_d    = '0;
        rd_d    = 1'b1;
        wdata_d = '0;
      end
    end else if ((state_q == S_ISSUE) && inport_accept_i) begin
      state_d = S_IDLE;
      wr_d    = '0;
      rd_d    = 1'b0;
      wdata_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      wr_q     <= '0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      req_id_q <= '0;
      id_cnt_q <= 16'h0001;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      req_id_q <= req_id_d;
      id_cnt_q <= id_cnt_d;
    end
  end

  // Tracking FIFO: one entry per captured request, retired in order by acks
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (capture) begin
        fifo_q[wptr_q] <= new_entry;
        wptr_q         <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(capture) - CW'(pop);
    end
  end

  always_comb begin
    resp_valid_d = pop;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    if (pop) begin
      resp_rdata_d = head.we ? 32'h0 : inport_read_data_i[32*head.lane +: 32];
      resp_err_d   = inport_error_i | head.err | id_mismatch;
    end
`ifdef DDR3_BRIDGE_ID_CHECK_EN
    id_err_d = id_err_q | (inport_ack_i && fifo_empty) | id_mismatch;
`else
    id_err_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      id_err_q     <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      id_err_q     <= id_err_d;
    end
  end

  assign inport_wr_o         = wr_q;
  assign inport_rd_o         = rd_q;
  assign inport_addr_o       = addr_q;
  assign inport_write_data_o = wdata_q;
  assign inport_req_id_o     = req_id_q;
  assign resp_valid_o        = resp_valid_q;
  assign resp_rdata_o        = resp_rdata_q;
  assign resp_err_o          = resp_err_q;
  assign busy_o              = !fifo_empty;
  assign id_err_o            = id_err_q;

endmodule

// File: tb/tb_ddr3_req_bridge32.sv
// Self-checking bench for ddr3_req_bridge32: queue-based reference model plus directed literal checks.
module tb_ddr3_req_bridge32;
  localparam int OUT = 4;

`ifdef DDR3_BRIDGE_ID_CHECK_EN
  localparam bit IDCHK = 1'b1;
`else
  localparam bit IDCHK = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b1;
  logic         req_valid_i = 1'b0;
  logic         req_ready_o;
  logic         req_we_i = 1'b0;
  logic [31:0]  req_addr_i = '0;
  logic [31:0]  req_wdata_i = '0;
  logic [3:0]   req_be_i = '0;
  logic         resp_valid_o;
  logic [31:0]  resp_rdata_o;
  logic         resp_err_o;
  logic         busy_o;
  logic         id_err_o;
  logic [15:0]  inport_wr_o;
  logic         inport_rd_o;
  logic [31:0]  inport_addr_o;
  logic [127:0] inport_write_data_o;
  logic [15:0]  inport_req_id_o;
  logic         inport_accept_i = 1'b0;
  logic         inport_ack_i = 1'b0;
  logic         inport_error_i = 1'b0;
  logic [15:0]  inport_resp_id_i = '0;
  logic [127:0] inport_read_data_i = '0;

  always #5 clk_i = ~clk_i;

  ddr3_req_bridge32 #(.OUTSTANDING(OUT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .busy_o(busy_o), .id_err_o(id_err_o),
    .inport_wr_o(inport_wr_o), .inport_rd_o(inport_rd_o), .inport_addr_o(inport_addr_o),
    .inport_write_data_o(inport_write_data_o), .inport_req_id_o(inport_req_id_o),
    .inport_accept_i(inport_accept_i), .inport_ack_i(inport_ack_i),
    .inport_error_i(inport_error_i), .inport_resp_id_i(inport_resp_id_i),
    .inport_read_data_i(inport_read_data_i)
  );

  typedef struct {
    int unsigned id;
    int unsigned lane;
    bit          we;
    bit          err;
  } ent_t;

  ent_t         q[$];
  bit           h_valid;
  logic [31:0]  h_addr;
  logic [15:0]  h_wr;
  bit           h_rd;
  logic [127:0] h_data;
  int unsigned  h_id;
  int unsigned  next_id;
  bit           e_rv;
  logic [31:0]  e_rd;
  bit           e_err;
  bit           e_iderr;
  int           nvec = 0;
  int           nerr = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (!h_valid || inport_accept_i) && (q.size() < OUT);
  endfunction

  task automatic model_reset();
    q.delete();
    h_valid = 0; h_addr = '0; h_wr = '0; h_rd = 0; h_data = '0; h_id = 0;
    next_id = 1;
    e_rv = 0; e_rd = '0; e_err = 0; e_iderr = 0;
  endtask

  task automatic check_all();
    chk("req_ready", req_ready_o, m_ready());
    chk("resp_valid", resp_valid_o, e_rv);
    chk("resp_rdata", resp_rdata_o, e_rd);
    chk("resp_err", resp_err_o, e_err);
    chk("busy", busy_o, q.size() != 0);
    chk("id_err", id_err_o, e_iderr);
    chk("inport_wr", inport_wr_o, h_valid ? h_wr : 16'h0);
    chk("inport_rd", inport_rd_o, h_valid ? h_rd : 1'b0);
    chk("inport_wdata", inport_write_data_o, h_valid ? h_data : 128'h0);
    if (h_valid) begin
      chk("inport_addr", inport_addr_o, h_addr);
      chk("inport_id", inport_req_id_o, h_id);
    end
  endtask

  // Advance the reference model by one clock edge using the inputs presented in that cycle.
  task automatic model_step();
    bit   cap, illegal, mis;
    ent_t e;
    int unsigned ln;
    cap = req_valid_i && m_ready();
    e_rv = 0; e_rd = '0; e_err = 0;
    if (inport_ack_i) begin
      if (q.size() != 0) begin
        e = q.pop_front();
        mis = IDCHK && (inport_resp_id_i != 16'(e.id));
        e_rv = 1;
        e_rd = e.we ? 32'h0 : 32'(inport_read_data_i >> (32 * e.lane));
        e_err = inport_error_i || e.err || mis;
        if (mis) e_iderr = 1;
      end else if (IDCHK) begin
        e_iderr = 1;
      end
    end
    if (cap) begin
      ln = req_addr_i[3:2];
      illegal = req_we_i && (req_be_i == 4'h0);
      h_valid = 1;
      h_addr = req_addr_i & 32'hFFFF_FFF0;
      h_id = next_id;
      h_wr = '0;
      if (req_we_i && !illegal) begin
        h_rd = 0;
        for (int b = 0; b < 4; b++) if (req_be_i[b]) h_wr[4 * ln + b] = 1'b1;
        h_data = {4{req_wdata_i}};
      end else begin
        h_rd = 1;
        h_data = '0;
      end
      q.push_back('{next_id, ln, req_we_i, illegal});
      next_id = (next_id == 32'd65535) ? 1 : next_id + 1;
    end else if (inport_accept_i) begin
      h_valid = 0;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit v, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input bit acc, input bit ack, input bit err,
                       input logic [15:0] rid, input logic [127:0] rdat);
    req_valid_i = v; req_we_i = we; req_addr_i = a; req_wdata_i = wd; req_be_i = be;
    inport_accept_i = acc; inport_ack_i = ack; inport_error_i = err;
    inport_resp_id_i = rid; inport_read_data_i = rdat;
    #1;
    check_all();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
  endtask

  task automatic idle(input bit acc);
    cycle(0, 0, 32'h0, 32'h0, 4'h0, acc, 0, 0, 16'h0, 128'h0);
  endtask

  task automatic do_reset();
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_wr", inport_wr_o, 16'h0);
    chk("rst_rd", inport_rd_o, 1'b0);
    chk("rst_addr", inport_addr_o, 32'h0);
    chk("rst_wdata", inport_write_data_o, 128'h0);
    chk("rst_id", inport_req_id_o, 16'h0);
    chk("rst_resp_valid", resp_valid_o, 1'b0);
    chk("rst_resp_rdata", resp_rdata_o, 32'h0);
    chk("rst_resp_err", resp_err_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_id_err", id_err_o, 1'b0);
    req_valid_i = 0; req_we_i = 0; req_be_i = 0; inport_accept_i = 0;
    inport_ack_i = 0; inport_error_i = 0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  initial begin
    logic [127:0] bb_data;
    model_reset();
    do_reset();
    #1 chk("rst_ready", req_ready_o, 1'b1);

    // Masked write then read of the same word
    cycle(1, 1, 32'h24, 32'hDEADBEEF, 4'b0110, 0, 0, 0, 16'h0, 128'h0);
    chk("mw_addr", inport_addr_o, 32'h20);
    chk("mw_wr", inport_wr_o, 16'h0060);
    chk("mw_data", inport_write_data_o, {4{32'hDEADBEEF}});
    chk("mw_id", inport_req_id_o, 16'd1);
    idle(1);
    cycle(0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 16'd1, {4{32'hCAFEF00D}});
    chk("mw_resp_valid", resp_valid_o, 1'b1);
    chk("mw_resp_rdata", resp_rdata_o, 32'h0);
    cycle(1, 0, 32'h24, 32'h0, 4'h0, 0, 0, 0, 16'h0, 128'h0);
    chk("mr_rd", inport_rd_o, 1'b1);
    idle(1);
    cycle(0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 16'd2, 128'h00000000_00000000_DEADBEEF_00000000);
    chk("mr_resp_rdata", resp_rdata_o, 32'hDEADBEEF);
    chk("mr_resp_err", resp_err_o, 1'b0);
    idle(0);

    // Back-to-back reads with accept held high
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0, 32'(4 * k), 32'h0, 4'h0, 1, 0, 0, 16'h0, 128'h0);
      chk("bb_id", inport_req_id_o, 16'(k + 1));
    end
    idle(1);
    bb_data = 128'h33333333_22222222_11111111_00000000;
    for (int k = 0; k < 4; k++) begin
      cycle(0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 16'(k + 1), bb_data);
      chk("bb_resp", resp_rdata_o, 32'h11111111 * k);
    end
    idle(0);

    // Full FIFO: six offers, no acks
    do_reset();
    for (int k = 0; k < 6; k++) cycle(1, 0, 32'(16 * k), 32'h0, 4'h0, 1, 0, 0, 16'h0, 128'h0);
    chk("full_busy", busy_o, 1'b1);
    chk("full_ready", req_ready_o, 1'b0);
    chk("full_last_id", inport_req_id_o, 16'd4);
    cycle(1, 0, 32'h100, 32'h0, 4'h0, 1, 1, 0, 16'd1, 128'h0);
    chk("full_reopen", req_ready_o, 1'b1);
    cycle(1, 0, 32'h200, 32'h0, 4'h0, 1, 0, 0, 16'h0, 128'h0);
    chk("full_one_slot", req_ready_o, 1'b0);
    chk("full_new_id", inport_req_id_o, 16'd5);
    idle(1);

    // Illegal write (no byte enables)
    do_reset();
    cycle(1, 1, 32'h30, 32'h12345678, 4'h0, 0, 0, 0, 16'h0, 128'h0);
    chk("ill_rd", inport_rd_o, 1'b1);
    chk("ill_wr", inport_wr_o, 16'h0);
    idle(1);
    cycle(0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 16'd1, {4{32'hFFFFFFFF}});
    chk("ill_resp_err", resp_err_o, 1'b1);
    chk("ill_resp_rdata", resp_rdata_o, 32'h0);
    idle(0);

    // Accept stall, then asynchronous reset mid-flight
    do_reset();
    cycle(1, 1, 32'h1008, 32'hA5A5_5A5A, 4'hF, 0, 0, 0, 16'h0, 128'h0);
    chk("stall_wr0", inport_wr_o, 16'h0F00);
    for (int k = 0; k < 10; k++) cycle(1, 0, $urandom, $urandom, 4'hF, 0, 0, 0, 16'h0, 128'h0);
    chk("stall_wr", inport_wr_o, 16'h0F00);
    chk("stall_addr", inport_addr_o, 32'h1000);
    chk("stall_id", inport_req_id_o, 16'd1);
    do_reset();
    cycle(1, 0, 32'h40, 32'h0, 4'h0, 0, 0, 0, 16'h0, 128'h0);
    chk("post_rst_id", inport_req_id_o, 16'd1);
    idle(1);

    // Response ID mismatch
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1, 0, 32'(16 * k), 32'h0, 4'h0, 1, 0, 0, 16'h0, 128'h0);
    idle(1);
    cycle(0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 16'd1, 128'h0);
    cycle(0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 16'd2, 128'h0);
    cycle(0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 0, 16'd5, 128'h0);
`ifdef DDR3_BRIDGE_ID_CHECK_EN
    chk("idm_err", resp_err_o, 1'b1);
    chk("idm_sticky", id_err_o, 1'b1);
    idle(0);
    chk("idm_sticky_hold", id_err_o, 1'b1);
`else
    chk("idm_err", resp_err_o, 1'b0);
    chk("idm_sticky", id_err_o, 1'b0);
    idle(0);
    chk("idm_sticky_hold", id_err_o, 1'b0);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit          v, we, acc, ack, err;
      logic [3:0]  be;
      logic [15:0] rid;
      if (i == 1500) do_reset();
      v   = $urandom_range(0, 1) != 0;
      we  = $urandom_range(0, 1) != 0;
      be  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      acc = $urandom_range(0, 2) != 0;
      ack = (q.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      err = $urandom_range(0, 9) == 0;
      rid = (q.size() != 0 && $urandom_range(0, 7) != 0) ? 16'(q[0].id) : 16'($urandom);
      cycle(v, we, $urandom, $urandom, be, acc, ack, err, rid,
            {$urandom, $urandom, $urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
